// File: rtl/lcb_word_assembler.sv
// lcb_word_assembler
//   Rebuilds 12-bit orbit words from the LCB byte stream and writes them into a
//   2048-entry RAM. A frame is the HEADER byte followed by N_WORDS byte pairs
//   (high byte = word[11:4], low nibble of the second byte = word[3:0]).
//
// Ports
//   clk       80 MHz system clock
//   rst       synchronous active-low reset
//   iData     received byte from the UART receiver
//   iValid    one-cycle strobe qualifying iData
//   iSync     buffer-swap strobe: address back to 0, frame abandoned
//   oWord     assembled word (registered)
//   oWE       one-cycle write strobe for oWord / oWrAddr
//   oWrAddr   RAM address of the current oWord
//   oDone     pulses together with the oWE of the last word of a frame
//   oTimeout  pulses when a frame is abandoned after an inter-byte gap
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | hunting for HEADER, all other bytes discarded
// HI    | waiting for the high byte of the next word
// LO    | high byte latched, waiting for the low byte
module lcb_word_assembler #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         N_WORDS = 16,
    parameter int         TIMEOUT = 800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  iData,
    input  logic        iValid,
    input  logic        iSync,
    output logic [11:0] oWord,
    output logic        oWE,
    output logic [10:0] oWrAddr,
    output logic        oDone,
    output logic        oTimeout
);

    localparam int             GAP_W     = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);
    localparam logic [7:0]     LAST_WORD = 8'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } stateType;

    stateType         state;
    stateType         stateNext;
    logic [7:0]       hiLatch;
    logic [7:0]       wordCnt;
    logic [GAP_W-1:0] gapCnt;

    logic gapExpired;
    logic lastWord;
    logic headerSeen;
    logic hiStrobe;
    logic wordStrobe;
    logic frameDone;
    logic timeoutHit;

    assign gapExpired = (gapCnt == GAP_LAST);
    assign lastWord   = (wordCnt == LAST_WORD);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; iSync overrides everything, a byte beats the timeout
    always_comb begin
        stateNext = state;
        if (iSync) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: if (iValid && iData == HEADER) stateNext = HI;
                HI: begin
                    if (iValid)          stateNext = LO;
                    else if (gapExpired) stateNext = IDLE;
                end
                LO: begin
                    if (iValid)          stateNext = lastWord ? IDLE : HI;
                    else if (gapExpired) stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Output decode (registered in the datapath below)
    always_comb begin
        headerSeen = 1'b0;
        hiStrobe   = 1'b0;
        wordStrobe = 1'b0;
        frameDone  = 1'b0;
        timeoutHit = 1'b0;
        if (!iSync) begin
            headerSeen = (state == IDLE) && iValid && (iData == HEADER);
            hiStrobe   = (state == HI) && iValid;
            wordStrobe = (state == LO) && iValid;
            frameDone  = wordStrobe && lastWord;
            timeoutHit = (state != IDLE) && !iValid && gapExpired;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            oWord    <= 12'h000;
            oWE      <= 1'b0;
            oWrAddr  <= 11'h000;
            oDone    <= 1'b0;
            oTimeout <= 1'b0;
            hiLatch  <= 8'h00;
            wordCnt  <= 8'h00;
            gapCnt   <= '0;
        end else begin
            oWE      <= wordStrobe;
            oDone    <= frameDone;
            oTimeout <= timeoutHit;

            if (wordStrobe) oWord <= {hiLatch, iData[3:0]};
            if (hiStrobe)   hiLatch <= iData;

            // Address moves on in the cycle after the write so oWrAddr
            // always matches the oWord being strobed; wraps naturally.
            if (iSync)    oWrAddr <= 11'h000;
            else if (oWE) oWrAddr <= oWrAddr + 11'd1;

            if (headerSeen)      wordCnt <= 8'h00;
            else if (wordStrobe) wordCnt <= wordCnt + 8'd1;

            if (iValid || iSync || state == IDLE || gapExpired) gapCnt <= '0;
            else                                                gapCnt <= gapCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_lcb_word_assembler.sv
`timescale 1ns/100ps
module tb_lcb_word_assembler;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int         NW  = 16;
    localparam int         TO  = 800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  iData = 8'h00;
    logic        iValid = 1'b0;
    logic        iSync = 1'b0;
    logic [11:0] oWord;
    logic        oWE;
    logic [10:0] oWrAddr;
    logic        oDone;
    logic        oTimeout;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: byte position within the frame and timestamps
    bit mInFrame = 0;
    int mPos = 0;
    int mLast = 0;
    int mCyc = 0;
    int mHi = 0;
    int mAddr = 0;
    int mWord = 0;
    bit mWE = 0, mDone = 0, mTo = 0;

    bit prevWE = 0, prevDone = 0, prevTo = 0;
    int weSeen = 0, doneSeen = 0, toSeen = 0;

    lcb_word_assembler #(.HEADER(HDR), .N_WORDS(NW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .iData(iData), .iValid(iValid), .iSync(iSync),
        .oWord(oWord), .oWE(oWE), .oWrAddr(oWrAddr), .oDone(oDone), .oTimeout(oTimeout)
    );

    always #6.25 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, mCyc);
        end
    endtask

    task automatic modelStep(input bit r, input bit s, input bit v, input logic [7:0] d);
        mCyc++;
        if (!r) begin
            mInFrame = 0; mAddr = 0; mWord = 0; mWE = 0; mDone = 0; mTo = 0;
            return;
        end
        mAddr = s ? 0 : (mWE ? (mAddr + 1) % 2048 : mAddr);
        mWE = 0; mDone = 0; mTo = 0;
        if (s) begin
            mInFrame = 0;
        end else if (v) begin
            mLast = mCyc;
            if (!mInFrame) begin
                if (d == HDR) begin
                    mInFrame = 1;
                    mPos = 0;
                end
            end else begin
                if (mPos % 2 == 0) begin
                    mHi = int'(d);
                end else begin
                    mWE = 1;
                    mWord = mHi * 16 + int'(d) % 16;
                    if ((mPos + 1) / 2 == NW) begin
                        mDone = 1;
                        mInFrame = 0;
                    end
                end
                mPos++;
            end
        end else if (mInFrame && (mCyc - mLast) == TO) begin
            mInFrame = 0;
            mTo = 1;
        end
    endtask

    task automatic step(input bit s, input bit v, input logic [7:0] d, input bit r = 1'b1);
        rst = r; iSync = s; iValid = v; iData = d;
        @(posedge clk);
        modelStep(r, s, v, d);
        #1;
        checkVal("we", oWE, mWE);
        checkVal("done", oDone, mDone);
        checkVal("timeout", oTimeout, mTo);
        checkVal("addr", oWrAddr, mAddr);
        checkVal("word", oWord, mWord);
        if (oWE)      checkVal("we_single", prevWE, 0);
        if (oDone)    checkVal("done_single", prevDone, 0);
        if (oTimeout) checkVal("timeout_single", prevTo, 0);
        prevWE = oWE; prevDone = oDone; prevTo = oTimeout;
        weSeen += oWE; doneSeen += oDone; toSeen += oTimeout;
    endtask

    task automatic sendByte(input logic [7:0] d);
        step(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic sendFrame(input logic [7:0] base);
        sendByte(HDR);
        for (int k = 0; k < NW; k++) begin
            sendByte(base + 8'(k));
            sendByte(8'hF3);
        end
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b1, HDR, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checkVal("rst_word", oWord, 12'h000);
        checkVal("rst_addr", oWrAddr, 11'h000);
        idle(2);

        // Full frame, explicit per-word checks
        weSeen = 0; doneSeen = 0;
        sendByte(HDR);
        for (int k = 0; k < NW; k++) begin
            sendByte(8'h12 + 8'(k));
            sendByte(8'hF3);
            checkVal("frame_word", oWord, {8'h12 + 8'(k), 4'h3});
            checkVal("frame_addr", oWrAddr, k);
            checkVal("frame_done", oDone, (k == NW - 1) ? 1 : 0);
        end
        idle(1);
        checkVal("frame_we_count", weSeen, NW);
        checkVal("frame_done_count", doneSeen, 1);

        // Timeout after a lone high byte
        weSeen = 0; toSeen = 0;
        sendByte(HDR);
        sendByte(8'hAB);
        for (int i = 1; i <= TO; i++) begin
            step(1'b0, 1'b0, 8'h00);
            checkVal("to_pulse", oTimeout, (i == TO) ? 1 : 0);
        end
        idle(2);
        checkVal("to_no_we", weSeen, 0);
        checkVal("to_count", toSeen, 1);
        sendByte(HDR);
        sendByte(8'h12);
        sendByte(8'h34);
        checkVal("to_next_word", oWord, 12'h124);
        checkVal("to_addr_kept", oWrAddr, 16);

        // Byte arriving on the would-be timeout cycle wins
        toSeen = 0;
        sendByte(8'h56);
        idle(TO - 1);
        sendByte(8'h07);
        checkVal("to_vs_valid_we", oWE, 1);
        checkVal("to_vs_valid_word", oWord, 12'h567);
        idle(3);
        checkVal("to_vs_valid_noto", toSeen, 0);
        step(1'b1, 1'b0, 8'h00);

        // Sync collision in HI at address 37
        sendFrame(8'h40);
        sendFrame(8'h60);
        sendByte(HDR);
        for (int k = 0; k < 5; k++) begin
            sendByte(8'h80 + 8'(k));
            sendByte(8'h0C);
        end
        idle(1);
        checkVal("sync_pre_addr", oWrAddr, 37);
        weSeen = 0;
        step(1'b1, 1'b1, 8'h77);
        checkVal("sync_addr", oWrAddr, 0);
        sendByte(8'h77);
        sendByte(8'h03);
        idle(1);
        checkVal("sync_dropped", weSeen, 0);

        // Noise in IDLE, header value as data
        weSeen = 0;
        sendByte(8'h00);
        sendByte(8'hFF);
        sendByte(8'h5A);
        idle(1);
        checkVal("noise_quiet", weSeen, 0);
        sendByte(HDR);
        sendByte(HDR);
        sendByte(8'hE7);
        checkVal("hdr_as_data", oWord, 12'hA57);
        checkVal("hdr_as_data_addr", oWrAddr, 0);
        step(1'b1, 1'b0, 8'h00);

        // Wrap: 128 back-to-back frames fill 0..2047, next word at 0
        for (int f = 0; f < 128; f++) sendFrame(8'(f));
        sendByte(HDR);
        sendByte(8'hC1);
        sendByte(8'h0D);
        checkVal("wrap_we", oWE, 1);
        checkVal("wrap_addr", oWrAddr, 0);
        checkVal("wrap_word", oWord, 12'hC1D);

        // Reset mid-frame after 3 words
        step(1'b1, 1'b0, 8'h00);
        sendByte(HDR);
        for (int k = 0; k < 3; k++) begin
            sendByte(8'h30 + 8'(k));
            sendByte(8'h09);
        end
        sendByte(8'h3F);
        weSeen = 0; doneSeen = 0; toSeen = 0;
        step(1'b0, 1'b1, 8'h01, 1'b0);
        checkVal("rstmid_word", oWord, 0);
        checkVal("rstmid_addr", oWrAddr, 0);
        checkVal("rstmid_we", oWE, 0);
        idle(TO + 5);
        checkVal("rstmid_no_pulse", weSeen + doneSeen + toSeen, 0);
        sendByte(HDR);
        sendByte(8'h9A);
        sendByte(8'h0B);
        checkVal("rstmid_restart_addr", oWrAddr, 0);
        checkVal("rstmid_restart_word", oWord, 12'h9AB);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit r, s, v;
            logic [7:0] d;
            r = ($urandom_range(0, 999) != 0);
            s = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 9) == 0) ? HDR : 8'($urandom);
            step(s, v, d, r);
            if ($urandom_range(0, 399) == 0) idle($urandom_range(TO - 3, TO + 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
